// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with a refill FSM toward backing memory.
// Optional hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_responder #(
  parameter int INDEX_WIDTH = 5,
  parameter int LINE_WORDS  = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_mem_action,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_addr_next,
  input  logic [31:0]           req_data,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [31:0]           mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [1:0]            fsm_state
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - INDEX_WIDTH;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_WAIT, WRITE_THRU} state_t;
  state_t state, state_n;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES*LINE_WORDS];

  logic [OFF_W-1:0]       req_off;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_W-1:0]       req_tag;
  assign req_off = req_addr[2 +: OFF_W];
  assign req_idx = req_addr[2+OFF_W +: INDEX_WIDTH];
  assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];

  logic [ADDR_WIDTH-3:0]  lat_word;
  logic [31:0]            lat_data;
  logic [INDEX_WIDTH-1:0] lat_idx;
  logic [TAG_W-1:0]       lat_tag;
  assign lat_idx = lat_word[OFF_W +: INDEX_WIDTH];
  assign lat_tag = lat_word[ADDR_WIDTH-3 -: TAG_W];

  logic [OFF_W-1:0] req_beat, rsp_beat;

  logic unused_bits;
  assign unused_bits = ^{req_addr_next, req_addr[1:0]};

  logic hit, idle_req, read_hit, read_miss, write_hit, rsp_fire, refill_done;
  assign hit         = req_valid && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_req    = (state == IDLE) && req_valid;
  assign read_hit    = idle_req && !req_mem_action && hit;
  assign read_miss   = idle_req && !req_mem_action && !hit;
  assign write_hit   = idle_req && req_mem_action && hit;
  // Refill data is accepted only while a refill is in flight, so stale returns after a reset are dropped.
  assign rsp_fire    = ((state == REFILL_REQ) || (state == REFILL_WAIT)) && mem_rsp_valid;
  assign refill_done = rsp_fire && (rsp_beat == LAST_BEAT);

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_beat <= '0;
      rsp_beat <= '0;
      lat_word <= '0;
      lat_data <= '0;
      valid_q  <= '0;
    end else begin
      state <= state_n;
      if (idle_req) begin
        req_beat <= '0;
        rsp_beat <= '0;
        lat_word <= req_addr[ADDR_WIDTH-1:2];
        lat_data <= req_data;
      end
      if ((state == REFILL_REQ) && mem_req_ready) req_beat <= req_beat + 1'b1;
      if (rsp_fire) rsp_beat <= rsp_beat + 1'b1;
      if (read_miss) valid_q[req_idx] <= 1'b0;
      if (refill_done) valid_q[lat_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_hit) data_q[{req_idx, req_off}] <= req_data;
    if (rsp_fire) data_q[{lat_idx, rsp_beat}] <= mem_rsp_data;
    if (refill_done) tag_q[lat_idx] <= lat_tag;
  end

  // Memory side: mem_req_valid holds with stable addr/we/wdata until a cycle with mem_req_ready,
  // and the transfer happens in that cycle. Requester side: req_* is held until the rsp_valid cycle.
  always_comb begin
    state_n       = state;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      IDLE: begin
        if (idle_req) begin
          if (req_mem_action) begin
            state_n = WRITE_THRU;
          end else if (hit) begin
            rsp_valid = 1'b1;
            rsp_data  = data_q[{req_idx, req_off}];
          end else begin
            state_n = REFILL_REQ;
          end
        end
      end
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {lat_tag, lat_idx, req_beat, 2'b00};
        if (mem_req_ready && (req_beat == LAST_BEAT)) state_n = REFILL_WAIT;
        if (refill_done) state_n = IDLE;
      end
      REFILL_WAIT: begin
        if (refill_done) state_n = IDLE;
      end
      WRITE_THRU: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {lat_word, 2'b00};
        mem_req_wdata = lat_data;
        if (mem_req_ready) begin
          rsp_valid = 1'b1;
          state_n   = IDLE;
        end
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  // The hit that completes a missed request is the same request, so it is not counted again.
  logic from_refill;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count   <= '0;
      miss_count  <= '0;
      from_refill <= 1'b0;
    end else begin
      from_refill <= refill_done;
      if (read_hit && !from_refill) hit_count <= hit_count + 32'd1;
      if (read_miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule
